// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit RISC CPU controller.
// CPU_HALT_EN adds the HALT state to the state enum.
package cpu_pkg;

  // MOV-immediate and register writeback share S_WR: both assert write and go to IF1.
  // Merging them lets every state, HALT included, fit in a 4-bit encoding.
  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_IF1      = 4'd1,
    S_IF2      = 4'd2,
    S_UPD_PC   = 4'd3,
    S_DECODE   = 4'd4,
    S_WR       = 4'd5,
    S_GET_A    = 4'd6,
    S_GET_B    = 4'd7,
    S_EXEC     = 4'd8,
    S_MEM_CALC = 4'd9,
    S_MEM_ADDR = 4'd10,
    S_MEM_RD   = 4'd11,
    S_LDR_WB   = 4'd12,
    S_STR_GETB = 4'd13,
    S_MEM_WR   = 4'd14
`ifdef CPU_HALT_EN
    , S_HALT   = 4'd15
`endif
  } state_t;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_STR  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_CMP     = 2'b01;

  typedef struct packed {
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       addr_sel;
    logic       load_addr;
    logic [1:0] mem_cmd;
  } ctrl_t;

  // Moore output decode: strobes as a function of the state alone (CMP only gates loads).
  function automatic ctrl_t decode_ctrl(input state_t s, input logic is_cmp);
    ctrl_t c;
    c = '0;
    c.mem_cmd = MEM_NONE;
    case (s)
      S_RST:      begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
      S_IF1:      begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; end
      S_IF2:      begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; c.load_ir = 1'b1; end
      S_UPD_PC:   c.load_pc = 1'b1;
      S_WR:       c.write = 1'b1;
      S_GET_A:    c.loada = 1'b1;
      S_GET_B:    c.loadb = 1'b1;
      S_EXEC:     begin c.loadc = 1'b1; c.loads = is_cmp; end
      S_MEM_CALC: c.loadc = 1'b1;
      S_MEM_ADDR: c.load_addr = 1'b1;
      S_MEM_RD:   c.mem_cmd = MEM_READ;
      S_LDR_WB:   begin c.mem_cmd = MEM_READ; c.write = 1'b1; end
      S_STR_GETB: c.loadb = 1'b1;
      S_MEM_WR:   c.mem_cmd = MEM_WRITE;
      default:    ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// Moore FSM issuing per-cycle load/write strobes for the RISC datapath, PC/IR and memory.
// Define CPU_HALT_EN to build the HALT state and the halted port.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic [3:0] state_o
`ifdef CPU_HALT_EN
  , output logic     halted
`endif
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_LAT - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  ctrl_t            ctrl, ctrl_nx;
  logic             is_cmp;

  assign is_cmp  = (opcode == OP_ALU) && (op == OP_CMP);
  assign state_o = state;
  assign {loada, loadb, loadc, loads, write, load_ir, load_pc, reset_pc,
          addr_sel, load_addr, mem_cmd} = ctrl;

  // Next-state logic; outputs are pre-decoded from the next state so they register with it.
  always_comb begin
    state_nx = state;
    case (state)
      S_RST:      state_nx = S_IF1;
      S_IF1:      if (cnt == CNT_LAST) state_nx = S_IF2;
      S_IF2:      state_nx = S_UPD_PC;
      S_UPD_PC:   state_nx = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_MOV: begin
            if (op == OP_MOV_IMM)      state_nx = S_WR;
            else if (op == OP_MOV_REG) state_nx = S_GET_B;
            else                       state_nx = S_IF1;
          end
          OP_ALU, OP_LDR, OP_STR: state_nx = S_GET_A;
`ifdef CPU_HALT_EN
          OP_HALT: state_nx = S_HALT;
`endif
          default: state_nx = S_IF1;
        endcase
      end
      S_WR:       state_nx = S_IF1;
      S_GET_A:    state_nx = (opcode == OP_ALU) ? S_GET_B : S_MEM_CALC;
      S_GET_B:    state_nx = S_EXEC;
      S_EXEC:     state_nx = is_cmp ? S_IF1 : S_WR;
      S_MEM_CALC: state_nx = S_MEM_ADDR;
      S_MEM_ADDR: state_nx = (opcode == OP_LDR) ? S_MEM_RD : S_STR_GETB;
      S_MEM_RD:   if (cnt == CNT_LAST) state_nx = S_LDR_WB;
      S_LDR_WB:   state_nx = S_IF1;
      S_STR_GETB: state_nx = S_MEM_WR;
      S_MEM_WR:   state_nx = S_IF1;
`ifdef CPU_HALT_EN
      S_HALT:     state_nx = S_HALT;
`endif
      default:    state_nx = S_RST;
    endcase
    // Wait counter restarts on any state change, so it reads 0 on entry to IF1/MEM_RD.
    cnt_nx  = (state_nx != state) ? '0 : cnt + CNT_W'(1);
    ctrl_nx = decode_ctrl(state_nx, is_cmp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RST;
      cnt   <= '0;
      ctrl  <= decode_ctrl(S_RST, 1'b0);
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ctrl  <= ctrl_nx;
    end
  end

`ifdef CPU_HALT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted <= 1'b0;
    else        halted <= (state_nx == S_HALT);
  end
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: per-cycle expected state/strobe scoreboard.
// Instance a uses MEM_RD_LAT=1, instance b uses MEM_RD_LAT=3.
module tb_cpu_controller;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_na, rst_nb;
  logic [2:0] opcode;
  logic [1:0] op;
  wire  [11:0] oa, ob;
  wire  [3:0]  sta, stb;
`ifdef CPU_HALT_EN
  wire         ha, hb;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    state_t      s;
    logic [11:0] o;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  cpu_controller #(.MEM_RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_na), .opcode(opcode), .op(op),
    .loada(oa[11]), .loadb(oa[10]), .loadc(oa[9]), .loads(oa[8]), .write(oa[7]),
    .load_ir(oa[6]), .load_pc(oa[5]), .reset_pc(oa[4]), .addr_sel(oa[3]),
    .load_addr(oa[2]), .mem_cmd(oa[1:0]), .state_o(sta)
`ifdef CPU_HALT_EN
    , .halted(ha)
`endif
  );

  cpu_controller #(.MEM_RD_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_nb), .opcode(opcode), .op(op),
    .loada(ob[11]), .loadb(ob[10]), .loadc(ob[9]), .loads(ob[8]), .write(ob[7]),
    .load_ir(ob[6]), .load_pc(ob[5]), .reset_pc(ob[4]), .addr_sel(ob[3]),
    .load_addr(ob[2]), .mem_cmd(ob[1:0]), .state_o(stb)
`ifdef CPU_HALT_EN
    , .halted(hb)
`endif
  );

  // Expected strobes, bit order {loada,loadb,loadc,loads,write,load_ir,load_pc,reset_pc,addr_sel,load_addr,mem_cmd}.
  function automatic logic [11:0] exp_out(input state_t s, input bit cmp);
    logic [11:0] r;
    r = '0;
    case (s)
      S_RST:      begin r[5] = 1'b1; r[4] = 1'b1; end
      S_IF1:      begin r[3] = 1'b1; r[1:0] = 2'b01; end
      S_IF2:      begin r[3] = 1'b1; r[1:0] = 2'b01; r[6] = 1'b1; end
      S_UPD_PC:   r[5] = 1'b1;
      S_WR:       r[7] = 1'b1;
      S_GET_A:    r[11] = 1'b1;
      S_GET_B:    r[10] = 1'b1;
      S_EXEC:     begin r[9] = 1'b1; r[8] = cmp; end
      S_MEM_CALC: r[9] = 1'b1;
      S_MEM_ADDR: r[2] = 1'b1;
      S_MEM_RD:   r[1:0] = 2'b01;
      S_LDR_WB:   begin r[1:0] = 2'b01; r[7] = 1'b1; end
      S_STR_GETB: r[10] = 1'b1;
      S_MEM_WR:   r[1:0] = 2'b10;
      default:    ;
    endcase
    return r;
  endfunction

  task automatic push(input state_t s, input bit cmp);
    exp_t e;
    e.s = s;
    e.o = exp_out(s, cmp);
    q.push_back(e);
  endtask

  task automatic push_fetch(input int lat);
    for (int i = 0; i < lat; i++) push(S_IF1, 1'b0);
    push(S_IF2, 1'b0);
    push(S_UPD_PC, 1'b0);
    push(S_DECODE, 1'b0);
  endtask

  // Expected per-cycle trace of one instruction, starting at its first IF1 cycle.
  task automatic build(input logic [2:0] opc, input logic [1:0] opv, input int lat);
    bit cmp;
    cmp = (opc == 3'b101) && (opv == 2'b01);
    push_fetch(lat);
    case (opc)
      3'b110: begin
        if (opv == 2'b10) push(S_WR, 1'b0);
        else if (opv == 2'b00) begin
          push(S_GET_B, 1'b0); push(S_EXEC, 1'b0); push(S_WR, 1'b0);
        end
      end
      3'b101: begin
        push(S_GET_A, 1'b0); push(S_GET_B, 1'b0); push(S_EXEC, cmp);
        if (!cmp) push(S_WR, 1'b0);
      end
      3'b011: begin
        push(S_GET_A, 1'b0); push(S_MEM_CALC, 1'b0); push(S_MEM_ADDR, 1'b0);
        for (int i = 0; i < lat; i++) push(S_MEM_RD, 1'b0);
        push(S_LDR_WB, 1'b0);
      end
      3'b100: begin
        push(S_GET_A, 1'b0); push(S_MEM_CALC, 1'b0); push(S_MEM_ADDR, 1'b0);
        push(S_STR_GETB, 1'b0); push(S_MEM_WR, 1'b0);
      end
      default: ;
    endcase
  endtask

  task automatic sample(input int sel, output state_t st, output logic [11:0] o);
    if (sel == 0) begin st = state_t'(sta); o = oa; end
    else          begin st = state_t'(stb); o = ob; end
  endtask

  // Leaves the chosen DUT in its first IF1 cycle, sampled at a negedge.
  task automatic do_reset(input int sel);
    @(negedge clk);
    if (sel == 0) rst_na = 1'b0; else rst_nb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (sel == 0) rst_na = 1'b1; else rst_nb = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drain the scoreboard one cycle per entry, then require a return to IF1.
  task automatic drain(input int sel, input string name);
    state_t st;
    logic [11:0] o;
    exp_t e;
    int cyc;
    cyc = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      sample(sel, st, o);
      total++;
      if (st !== e.s || o !== e.o) begin
        bad++;
        $display("FAIL %s cyc%0d: got state=%0d out=%h, want state=%0d out=%h",
                 name, cyc, st, o, e.s, e.o);
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    sample(sel, st, o);
    total++;
    if (st !== S_IF1) begin
      bad++;
      $display("FAIL %s end: got state=%0d, want IF1 after %0d cycles", name, st, cyc);
    end
  endtask

  task automatic run_instr(input int sel, input logic [2:0] opc, input logic [1:0] opv,
                           input int lat, input string name);
    opcode = opc;
    op     = opv;
    build(opc, opv, lat);
    drain(sel, name);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst_na = 1'b0;
    #1;
    total++;
    if (sta !== 4'(S_RST) || {oa[5], oa[4], oa[1:0]} !== 4'b1100 || oa !== exp_out(S_RST, 1'b0)) begin
      bad++;
      $display("FAIL reset_async: got state=%0d out=%h, want state=%0d out=%h", sta, oa, S_RST,
               exp_out(S_RST, 1'b0));
    end
    @(negedge clk);
    rst_na = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (sta !== 4'(S_IF1) || oa !== exp_out(S_IF1, 1'b0)) begin
      bad++;
      $display("FAIL reset_release: got state=%0d out=%h, want state=%0d", sta, oa, S_IF1);
    end
    @(posedge clk);
    #1;
    total++;
    if (sta !== 4'(S_IF2) || oa[6] !== 1'b1) begin
      bad++;
      $display("FAIL reset_if2: got state=%0d load_ir=%b, want state=%0d load_ir=1", sta, oa[6], S_IF2);
    end
    do_reset(0);
  endtask

  task automatic test_mov();
    run_instr(0, OP_MOV, 2'b10, 1, "mov_imm");
    run_instr(0, OP_MOV, 2'b00, 1, "mov_reg");
  endtask

  task automatic test_alu();
    run_instr(0, OP_ALU, 2'b00, 1, "add");
    run_instr(0, OP_ALU, 2'b01, 1, "cmp");
    run_instr(0, OP_ALU, 2'b10, 1, "and");
    run_instr(0, OP_ALU, 2'b11, 1, "mvn");
  endtask

  task automatic test_mem();
    run_instr(0, OP_LDR, 2'b00, 1, "ldr_lat1");
    run_instr(0, OP_STR, 2'b00, 1, "str");
  endtask

  task automatic test_nop();
    run_instr(0, OP_MOV, 2'b01, 1, "nop_mov01");
    run_instr(0, 3'b000, 2'b00, 1, "nop_000");
  endtask

  task automatic test_ldr_lat3();
    do_reset(1);
    run_instr(1, OP_LDR, 2'b00, 3, "ldr_lat3");
    run_instr(1, OP_MOV, 2'b10, 3, "mov_imm_lat3");
    rst_nb = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    do_reset(0);
    opcode = OP_LDR;
    op     = 2'b00;
    for (int i = 0; i < 20 && !found; i++) begin
      if (sta == 4'(S_MEM_RD)) found = 1'b1;
      else begin @(posedge clk); @(negedge clk); end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reset_mid_reach: state=%0d, want MEM_RD within 20 cycles", sta);
    end
    #2 rst_na = 1'b0;
    #1;
    total++;
    if (sta !== 4'(S_RST) || oa[1:0] !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid: got state=%0d mem_cmd=%b, want state=%0d mem_cmd=00", sta, oa[1:0], S_RST);
    end
    do_reset(0);
  endtask

  task automatic test_halt();
`ifdef CPU_HALT_EN
    state_t st;
    logic [11:0] o;
    opcode = OP_HALT;
    op     = 2'b00;
    push_fetch(1);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      sample(0, st, o);
      total++;
      if (st !== e.s || o !== e.o) begin
        bad++;
        $display("FAIL halt_fetch: got state=%0d out=%h, want state=%0d out=%h", st, o, e.s, e.o);
      end
      @(posedge clk);
      @(negedge clk);
    end
    for (int i = 0; i < 22; i++) begin
      total++;
      if (sta !== 4'(S_HALT) || ha !== 1'b1 || oa !== 12'h000) begin
        bad++;
        $display("FAIL halt_hold cyc%0d: got state=%0d halted=%b out=%h, want state=%0d halted=1 out=000",
                 i, sta, ha, oa, S_HALT);
      end
      @(posedge clk);
      @(negedge clk);
    end
    do_reset(0);
`else
    run_instr(0, OP_HALT, 2'b00, 1, "nop_111");
`endif
  endtask

  task automatic test_back_to_back();
    logic [2:0] opcs [9] = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b101, 3'b101, 3'b011, 3'b100, 3'b000};
    logic [1:0] ops  [9] = '{2'b10,  2'b00,  2'b00,  2'b01,  2'b10,  2'b11,  2'b00,  2'b00,  2'b00};
    int k;
    for (int i = 0; i < 12; i++) begin
      k = int'($urandom_range(0, 8));
      run_instr(0, opcs[k], ops[k], 1, "b2b");
    end
  endtask

  initial begin
    rst_na = 1'b0;
    rst_nb = 1'b0;
    opcode = 3'b000;
    op     = 2'b00;
    test_reset();
    test_mov();
    test_alu();
    test_mem();
    test_nop();
    test_ldr_lat3();
    test_reset_mid();
    test_halt();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
